// File: rtl/rf_pkg.sv
// Shared constants, types and the bypass priority helper for the scoreboarded register file.
package rf_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int MAX_WR       = 2;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

  // Highest-index matching write port wins the forward.
  function automatic logic [1:0] bypass_select(input logic [MAX_WR-1:0] hit);
    logic [1:0] idx;
    idx = 2'd0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (hit[w]) begin
        idx = w[1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on allocation, cleared on writeback, allocation wins ties.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_WR   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_en_i,
  input  logic [AW-1:0]        alloc_addr_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  output logic [NUM_REGS-1:0]  busy_vec_o
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                set_s;
  logic                clr_s;

  // Next-state per register; x0 is never busy.
  always_comb begin
    busy_next_s = {NUM_REGS{1'b0}};
    set_s       = 1'b0;
    clr_s       = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      set_s = alloc_en_i && (alloc_addr_i == r[AW-1:0]);
      clr_s = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == r[AW-1:0])) begin
          clr_s = 1'b1;
        end else begin
          clr_s = clr_s;
        end
      end
      if (set_s) begin
        busy_next_s[r] = 1'b1;
      end else if (clr_s) begin
        busy_next_s[r] = 1'b0;
      end else begin
        busy_next_s[r] = busy_r[r];
      end
    end
  end

  // Busy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy_vec_o = busy_r;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with optional writeback forwarding and busy scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  bit BYPASS   = 1'b1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rs_addr_i,
  output logic [NUM_RD*XLEN-1:0] rs_data_o,
  output logic [NUM_RD-1:0]      rs_busy_o,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   alloc_en_i,
  input  logic [AW-1:0]          alloc_addr_i,
  output logic [NUM_REGS-1:0]    busy_vec_o
);

  logic [XLEN-1:0]     regs_r [NUM_REGS];
  logic [AW-1:0]       wr_addr_s [NUM_WR];
  logic [XLEN-1:0]     wr_data_s [NUM_WR];
  logic [NUM_REGS-1:0] busy_vec_s;
  logic [AW-1:0]       rd_addr_s;
  logic [MAX_WR-1:0]   hit_s;
  logic [1:0]          sel_s;
  logic                fwd_s;
  logic [XLEN-1:0]     rd_data_s;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .busy_vec_o   (busy_vec_s)
  );

  assign busy_vec_o = busy_vec_s;

  // Unpack flat writeback buses.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr_s[w] = wr_addr_i[w*AW +: AW];
      wr_data_s[w] = wr_data_i[w*XLEN +: XLEN];
    end
  end

  // Data array; later ports overwrite earlier ones on address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_s[w] != {AW{1'b0}})) begin
          regs_r[wr_addr_s[w]] <= wr_data_s[w];
        end
      end
    end
  end

  // Read muxes with forwarding; x0 always reads zero and never busy.
  always_comb begin
    rs_data_o = {(NUM_RD*XLEN){1'b0}};
    rs_busy_o = {NUM_RD{1'b0}};
    rd_addr_s = {AW{1'b0}};
    hit_s     = {MAX_WR{1'b0}};
    sel_s     = 2'd0;
    fwd_s     = 1'b0;
    rd_data_s = {XLEN{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr_s = rs_addr_i[k*AW +: AW];
      hit_s     = {MAX_WR{1'b0}};
      for (int w = 0; w < NUM_WR; w++) begin
        hit_s[w] = wr_en_i[w] && (wr_addr_s[w] == rd_addr_s);
      end
      sel_s     = bypass_select(hit_s);
      fwd_s     = BYPASS && (|hit_s);
      rd_data_s = regs_r[rd_addr_s];
      for (int w = 0; w < NUM_WR; w++) begin
        if (fwd_s && (sel_s == w[1:0])) begin
          rd_data_s = wr_data_s[w];
        end else begin
          rd_data_s = rd_data_s;
        end
      end
      if (rd_addr_s == {AW{1'b0}}) begin
        rs_data_o[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rs_busy_o[k]              = 1'b0;
      end else begin
        rs_data_o[k*XLEN +: XLEN] = rd_data_s;
        rs_busy_o[k]              = busy_vec_s[rd_addr_s] && !fwd_s;
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Next-generation integer register file: parametrised read/write port counts, optional write-to-read bypass, and a per-register busy scoreboard for pipeline hazard tracking.
- Sits between decode/issue (reads operands, allocates destinations) and writeback (one write port per retiring lane).
- Replaces the fixed 2R1W register file; x0 semantics are unchanged.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, register count; must be a power of two, at least 2.
- NUM_RD, 2, read port count, 1..4.
- NUM_WR, 1, write port count, 1..2.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = reads return stored value only.
- AW, $clog2(NUM_REGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_addr_i  in  NUM_RD*AW  read addresses; port k at [k*AW +: AW].
- rs_data_o  out  NUM_RD*XLEN  read data per port.
- rs_busy_o  out  NUM_RD  1 = addressed register has an outstanding producer.
- wr_en_i  in  NUM_WR  writeback enable per port.
- wr_addr_i  in  NUM_WR*AW  writeback address per port.
- wr_data_i  in  NUM_WR*XLEN  writeback data per port.
- alloc_en_i  in  1  issue allocates a destination register.
- alloc_addr_i  in  AW  destination register being allocated.
- busy_vec_o  out  NUM_REGS  registered scoreboard state; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Reset state: all registers 0; all busy bits 0; busy_vec_o = 0; rs_busy_o = 0.
- Register write: on rising clk with wr_en_i[w]=1 and wr_addr_i[w]!=0, reg[addr] <= data.
  - Writes to x0 are discarded.
  - If two ports target the same address in one cycle, the higher port index wins.
- Reads are combinational, zero latency.
  - Address 0 returns 0 and busy 0 regardless of any other input.
  - BYPASS=1 and a same-cycle write matches the address: rs_data_o = that write's data (highest-index match wins); otherwise the stored value.
  - BYPASS=0: stored value only; new data is visible the cycle after the write edge.
- Scoreboard, per register r != 0, evaluated at the clock edge:
  - set = alloc_en_i && alloc_addr_i==r
  - clr = any wr_en_i[w] && wr_addr_i[w]==r
  - next busy[r] = set ? 1 : (clr ? 0 : busy[r]). Allocation beats a same-cycle clear, because the new producer supersedes the retiring one.
  - Allocating a register that is already busy keeps it busy (WAW). The scoreboard does not count producers; issue stalls on busy destinations.
  - alloc_addr_i==0 is ignored.
- rs_busy_o[k]:
  - BYPASS=1: busy[addr] && !(same-cycle write to addr). The operand is forwarded, so issue need not stall.
  - BYPASS=0: busy[addr] only.
  - A same-cycle alloc to the same address does not affect the current read's busy (it takes effect next cycle).
- Reset mid-operation: rst_n low clears registers and scoreboard immediately; in-flight writes and allocs are lost.
- No X on outputs after reset, for any address input.

Decomposition:
- Package rf_pkg: default XLEN/NUM_REGS constants; typedef reg_addr_t (AW bits) and xdata_t (XLEN bits); function bypass_select(...) returning the winning write-port index.
- One sub-module, rf_scoreboard: busy bit array, set/clr priority, busy_vec_o, registered on clk/rst_n.
- The data array, write decode and read muxes stay in reg_file_sb.

Test Plan:
- Reset, then write x0=0xDEADBEEF and read port 0 at address 0 -> data 0x0, busy 0, busy_vec_o[0]=0.
- NUM_RD=3: write x1=0x12345678, x2=0xAAAAAAAA, x3=0x55555555, then read ports 0/1/2 at addresses 1/2/3 in the same cycle -> 0x12345678 / 0xAAAAAAAA / 0x55555555.
- BYPASS=1: x5 holds 0x105; in one cycle write x5=0xCAFEF00D and read x5 -> 0xCAFEF00D combinationally. Repeat with BYPASS=0 -> 0x105 that cycle, 0xCAFEF00D the next.
- NUM_WR=2: both ports write x7 in one cycle (port0 0x1111_1111, port1 0x2222_2222) -> x7=0x22222222. Both ports write x8 and x9 with different data -> both stored.
- Scoreboard:
  - alloc x10 -> busy_vec_o[10]=1 next cycle, rs_busy_o=1 when reading x10.
  - Writeback x10 with BYPASS=1 -> rs_busy_o=0 that cycle, busy cleared next cycle.
  - Alloc x11 and writeback x11 in the same cycle -> busy_vec_o[11] stays 1.
- Reset mid-operation: with x4=0xFFFFFFFF and x12 busy, pulse rst_n low for 3 ns between edges -> x4 reads 0 immediately and busy_vec_o=0. The wr_en_i=0 check also passes: driving address 5 with 0xBADBAD00 and no enable leaves x5 unchanged.
